// File: rtl/fake_netlist_vec_sequencer.sv
// Loads a wide input vector for a combinational fake netlist from a narrow word
// stream, applies it atomically, waits a settle time and returns the output bit.
module fake_netlist_vec_sequencer #(
  parameter int VEC_W  = 375,
  parameter int WORD_W = 32,
  parameter int SETTLE = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              word_valid_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              word_ready_o,
  output logic [VEC_W-1:0]  dut_vec_o,
  input  logic              dut_out_i,
  output logic              res_valid_o,
  output logic              res_bit_o,
  input  logic              res_ready_i,
  output logic              busy_o,
  input  logic              clear_i,
  output logic [15:0]       vec_count_o,
  output logic [15:0]       ones_count_o
);

  localparam int NWORDS   = (VEC_W + WORD_W - 1) / WORD_W;
  localparam int LAST_W   = VEC_W - (NWORDS - 1) * WORD_W;
  localparam int SHADOW_W = (NWORDS - 1) * WORD_W;
  localparam int IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SETTLE, ST_RESULT} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    settle_q, settle_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic [VEC_W-1:0]    dut_vec_q, dut_vec_d;
  logic                res_bit_q, res_bit_d;
  logic [15:0]         vec_cnt_q, vec_cnt_d;
  logic [15:0]         ones_cnt_q, ones_cnt_d;

  logic accept, last_word, capture;

  assign accept    = (state_q == ST_LOAD) && word_valid_i;
  assign last_word = (idx_q == IDX_W'(NWORDS - 1));
  assign capture   = (state_q == ST_SETTLE) && (settle_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      settle_q   <= '0;
      shadow_q   <= '0;
      dut_vec_q  <= '0;
      res_bit_q  <= 1'b0;
      vec_cnt_q  <= '0;
      ones_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      shadow_q   <= shadow_d;
      dut_vec_q  <= dut_vec_d;
      res_bit_q  <= res_bit_d;
      vec_cnt_q  <= vec_cnt_d;
      ones_cnt_q <= ones_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_i) state_d = ST_LOAD;
      ST_LOAD:   if (accept && last_word) state_d = ST_SETTLE;
      ST_SETTLE: if (capture) state_d = ST_RESULT;
      ST_RESULT: if (res_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The final word goes straight into the applied vector together with the
  // shadow, so the netlist never sees a partially loaded vector.
  always_comb begin
    idx_d      = idx_q;
    settle_d   = settle_q;
    shadow_d   = shadow_q;
    dut_vec_d  = dut_vec_q;
    res_bit_d  = res_bit_q;
    vec_cnt_d  = vec_cnt_q;
    ones_cnt_d = ones_cnt_q;

    if (state_q == ST_IDLE && start_i) idx_d = '0;
    else if (accept)                   idx_d = idx_q + 1'b1;

    for (int w = 0; w < NWORDS - 1; w++) begin
      if (accept && idx_q == IDX_W'(w)) shadow_d[w*WORD_W +: WORD_W] = word_i;
    end

    if (accept && last_word) begin
      dut_vec_d = {word_i[LAST_W-1:0], shadow_q};
      settle_d  = CNT_W'(SETTLE - 1);
    end else if (state_q == ST_SETTLE && settle_q != '0) begin
      settle_d = settle_q - 1'b1;
    end

    if (capture) res_bit_d = dut_out_i;

    if (clear_i) begin
      vec_cnt_d  = '0;
      ones_cnt_d = '0;
    end else if (capture) begin
      if (vec_cnt_q != 16'hFFFF)               vec_cnt_d  = vec_cnt_q + 16'd1;
      if (dut_out_i && ones_cnt_q != 16'hFFFF) ones_cnt_d = ones_cnt_q + 16'd1;
    end
  end

  always_comb begin
    word_ready_o = (state_q == ST_LOAD);
    res_valid_o  = (state_q == ST_RESULT);
    busy_o       = (state_q != ST_IDLE);
    res_bit_o    = res_bit_q;
    dut_vec_o    = dut_vec_q;
    vec_count_o  = vec_cnt_q;
    ones_count_o = ones_cnt_q;
  end

endmodule
